parser_feed_sched: RTL and testbench
====================================

Name: parser_feed_sched

Overview:
- Front-end scheduler for the ITCH message parser. It shares the parser between two 32-bit word-stream feeds (S0, S1) and arbitrates per whole message, round-robin.
- It assembles each accepted message into a NUM_WORDS-word frame (reg0..reg8 layout). It presents the frame on o_frame and issues a one-cycle o_data_valid when the downstream order book signals ready.
- It discards malformed frames and counts them.

Parameters:
- REG_WIDTH, 32, width of one message word / parser register.
- NUM_WORDS, 9, words per message frame.
- CNT_WIDTH, 16, width of the message and error counters.

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  synchronous active-high reset
- i_s0_data  in  REG_WIDTH  feed 0 word
- i_s0_valid  in  1  feed 0 word valid
- i_s0_last  in  1  feed 0 final word of message
- o_s0_ready  out  1  feed 0 word accepted when valid&ready
- i_s1_data  in  REG_WIDTH  feed 1 word
- i_s1_valid  in  1  feed 1 word valid
- i_s1_last  in  1  feed 1 final word of message
- o_s1_ready  out  1  feed 1 ready
- i_book_ready  in  1  downstream can take a message this cycle
- o_frame  out  NUM_WORDS*REG_WIDTH  word k at bits [k*REG_WIDTH +: REG_WIDTH]; word 0 = reg0
- o_data_valid  out  1  one-cycle issue pulse to parser
- o_src  out  1  source of the frame on o_frame
- o_msg_count  out  CNT_WIDTH  messages issued, saturating
- o_err_count  out  CNT_WIDTH  frames discarded for length errors, saturating

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Ports are i_clk, i_reset.
- Reset values: o_frame=0, o_data_valid=0, o_src=0, both counts=0, both ready=0, state=IDLE, last_grant=1 (S0 wins first tie).
- Reset mid-operation: the partial frame is abandoned. No issue occurs and no count changes.

FSM:
- IDLE:
  - If only one valid is high, grant that feed.
  - If both are high, grant the feed != last_grant.
  - Grant is registered, last_grant is updated, word counter idx is cleared, then go to COLLECT.
  - No ready is asserted in IDLE.
- COLLECT:
  - Ready is high only for the granted feed. The other feed's ready is 0.
  - On valid&ready, the word is written to frame buffer slot idx and idx increments.
  - Last word at idx==NUM_WORDS-1 -> ISSUE.
  - Last word at idx<NUM_WORDS-1 (short frame) -> err_count+1, go to IDLE. Buffer slots already written are not issued.
  - Word at idx==NUM_WORDS-1 without last (long frame) -> DRAIN.
- DRAIN:
  - Granted ready stays high and words are dropped.
  - On last: err_count+1 -> IDLE.
- ISSUE:
  - Ready is 0.
  - When i_book_ready=1: copy the buffer to o_frame, set o_src=grant, pulse o_data_valid for one cycle, msg_count+1 -> IDLE.
  - Otherwise hold in ISSUE indefinitely.

Timing and counters:
- Latency: last word accepted in cycle N with i_book_ready high -> o_data_valid high in cycle N+1. The earliest first-word acceptance is the cycle after IDLE sees valid.
- o_frame and o_src are stable between issues; they change only on the o_data_valid cycle.
- Counters saturate at all-ones and do not wrap.

Optional Feature:
- Macro: PARSER_TYPE_FILTER_EN.
- When defined: at ISSUE, if frame word0[7:0] is not 8'h41, 8'h44 or 8'h45, the frame is dropped with no pulse and msg_count unchanged. An extra output o_filt_count (CNT_WIDTH, saturating, reset 0) increments, and the FSM returns to IDLE without waiting for i_book_ready.
- When undefined: every correctly-sized frame is issued regardless of type, and o_filt_count does not exist.

Test Plan:
- Reset, then S0 sends 9 words 0x00000041..0x00000049 with last on word 9 and book_ready=1 -> one o_data_valid pulse. o_frame word0=0x41, word8=0x49, o_src=0, msg_count=1.
- S0 and S1 both valid continuously, each sending 9-word frames -> issues alternate src 0,1,0,1. The non-granted ready stays 0 throughout.
- S1 sends last on word 5 -> no pulse, err_count=1, then the next good 9-word frame issues normally.
- S0 sends 12 words with last on word 12 -> words 10-12 are accepted and dropped, err_count=1, no pulse.
- Complete frame with book_ready held 0 for 20 cycles -> both readies 0, no pulse. Pulse occurs the cycle book_ready rises. Assert i_reset during a second frame's word 4 -> state IDLE, all outputs at reset values.
- PARSER_TYPE_FILTER_EN defined, frame word0=0x00000058 -> no pulse, filt_count=1, msg_count unchanged.

Source files
------------

// File: rtl/parser_feed_sched.sv
// parser_feed_sched: shares the ITCH parser between two 32-bit word feeds.
// Arbitrates round-robin per whole message and gathers each accepted message
// into a NUM_WORDS-word frame. Issues the frame with a one-cycle o_data_valid
// once the order book is ready. Short and long frames are dropped and counted.
//
// Ports:
//   i_clk, i_reset            clock, synchronous active-high reset
//   i_sN_data/valid/last      feed N word stream (N = 0, 1)
//   o_sN_ready                feed N word accepted when valid & ready
//   i_book_ready              downstream can take a message this cycle
//   o_frame                   issued frame, word k at [k*REG_WIDTH +: REG_WIDTH]
//   o_data_valid              one-cycle issue pulse
//   o_src                     feed that supplied the frame on o_frame
//   o_msg_count, o_err_count  saturating issue / length-error counters
//
// Optional build macro PARSER_TYPE_FILTER_EN: frames whose word0[7:0] is not
// 8'h41, 8'h44 or 8'h45 are dropped at issue time and counted on o_filt_count.
module parser_feed_sched #(
  parameter int unsigned REG_WIDTH = 32,
  parameter int unsigned NUM_WORDS = 9,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                           i_clk,
  input  logic                           i_reset,
  input  logic [REG_WIDTH-1:0]           i_s0_data,
  input  logic                           i_s0_valid,
  input  logic                           i_s0_last,
  output logic                           o_s0_ready,
  input  logic [REG_WIDTH-1:0]           i_s1_data,
  input  logic                           i_s1_valid,
  input  logic                           i_s1_last,
  output logic                           o_s1_ready,
  input  logic                           i_book_ready,
  output logic [NUM_WORDS*REG_WIDTH-1:0] o_frame,
  output logic                           o_data_valid,
  output logic                           o_src,
  output logic [CNT_WIDTH-1:0]           o_msg_count,
  output logic [CNT_WIDTH-1:0]           o_err_count
`ifdef PARSER_TYPE_FILTER_EN
  ,
  output logic [CNT_WIDTH-1:0]           o_filt_count
`endif
);

  localparam int unsigned IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_ISSUE   = 2'd3
  } state_e;

  typedef logic [NUM_WORDS-1:0][REG_WIDTH-1:0] frame_t;

  state_e               state_q, state_d;
  logic                 last_grant_q, last_grant_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  frame_t               buf_q, buf_d, frame_q, frame_d;
  logic                 dv_q, dv_d;
  logic                 src_q, src_d;
  logic [CNT_WIDTH-1:0] msg_q, msg_d, err_q, err_d;
`ifdef PARSER_TYPE_FILTER_EN
  logic [CNT_WIDTH-1:0] filt_q, filt_d;
`endif

  logic [REG_WIDTH-1:0] sel_data;
  logic                 sel_valid, sel_last, accept, at_end;
  logic                 type_ok, issue_done, try_issue;
  frame_t               buf_upd, issue_frame;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_WIDTH'(1);
  endfunction

  // Granted feed's word stream
  assign sel_data  = last_grant_q ? i_s1_data  : i_s0_data;
  assign sel_valid = last_grant_q ? i_s1_valid : i_s0_valid;
  assign sel_last  = last_grant_q ? i_s1_last  : i_s0_last;
  assign accept    = ((state_q == ST_COLLECT) || (state_q == ST_DRAIN)) && sel_valid;
  assign at_end    = (idx_q == LAST_IDX);

  // Buffer with the word being accepted merged in, so a final word taken while
  // the book is ready can be issued on the very next cycle
  always_comb begin
    buf_upd        = buf_q;
    buf_upd[idx_q] = sel_data;
  end

  assign issue_frame = (state_q == ST_ISSUE) ? buf_q : buf_upd;

`ifdef PARSER_TYPE_FILTER_EN
  assign type_ok = (issue_frame[0][7:0] == 8'h41) || (issue_frame[0][7:0] == 8'h44) ||
                   (issue_frame[0][7:0] == 8'h45);
`else
  assign type_ok = 1'b1;
`endif

  // A pending frame leaves when it is either issued or filtered away
  assign issue_done = ~type_ok | i_book_ready;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (i_s0_valid || i_s1_valid) state_d = ST_COLLECT;
      ST_COLLECT: if (accept) begin
        if (sel_last)    state_d = (!at_end || issue_done) ? ST_IDLE : ST_ISSUE;
        else if (at_end) state_d = ST_DRAIN;
      end
      ST_DRAIN:   if (accept && sel_last) state_d = ST_IDLE;
      ST_ISSUE:   if (issue_done) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Output and datapath next-values
  always_comb begin
    last_grant_d = last_grant_q;
    idx_d        = idx_q;
    buf_d        = buf_q;
    frame_d      = frame_q;
    src_d        = src_q;
    dv_d         = 1'b0;
    msg_d        = msg_q;
    err_d        = err_q;
`ifdef PARSER_TYPE_FILTER_EN
    filt_d       = filt_q;
`endif
    try_issue    = 1'b0;
    o_s0_ready   = 1'b0;
    o_s1_ready   = 1'b0;
    case (state_q)
      ST_IDLE: if (i_s0_valid || i_s1_valid) begin
        // Tie goes to the feed that was not granted last
        last_grant_d = (i_s0_valid && i_s1_valid) ? ~last_grant_q : i_s1_valid;
        idx_d        = '0;
      end
      ST_COLLECT: begin
        o_s0_ready = ~last_grant_q;
        o_s1_ready = last_grant_q;
        if (accept) begin
          buf_d = buf_upd;
          if (!at_end) idx_d = idx_q + IDX_W'(1);
          if (sel_last && !at_end) err_d = sat_inc(err_q);
          if (sel_last && at_end)  try_issue = 1'b1;
        end
      end
      ST_DRAIN: begin
        o_s0_ready = ~last_grant_q;
        o_s1_ready = last_grant_q;
        if (accept && sel_last) err_d = sat_inc(err_q);
      end
      ST_ISSUE: try_issue = 1'b1;
      default: ;
    endcase
    if (try_issue && type_ok && i_book_ready) begin
      frame_d = issue_frame;
      src_d   = last_grant_q;
      dv_d    = 1'b1;
      msg_d   = sat_inc(msg_q);
    end
`ifdef PARSER_TYPE_FILTER_EN
    if (try_issue && !type_ok) filt_d = sat_inc(filt_q);
`endif
  end

  // Datapath registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      last_grant_q <= 1'b1;
      idx_q        <= '0;
      buf_q        <= '0;
      frame_q      <= '0;
      src_q        <= 1'b0;
      dv_q         <= 1'b0;
      msg_q        <= '0;
      err_q        <= '0;
`ifdef PARSER_TYPE_FILTER_EN
      filt_q       <= '0;
`endif
    end else begin
      last_grant_q <= last_grant_d;
      idx_q        <= idx_d;
      buf_q        <= buf_d;
      frame_q      <= frame_d;
      src_q        <= src_d;
      dv_q         <= dv_d;
      msg_q        <= msg_d;
      err_q        <= err_d;
`ifdef PARSER_TYPE_FILTER_EN
      filt_q       <= filt_d;
`endif
    end
  end

  assign o_frame      = frame_q;
  assign o_data_valid = dv_q;
  assign o_src        = src_q;
  assign o_msg_count  = msg_q;
  assign o_err_count  = err_q;
`ifdef PARSER_TYPE_FILTER_EN
  assign o_filt_count = filt_q;
`endif

endmodule

// File: tb/tb_parser_feed_sched.sv
`timescale 1ns/1ps
module tb_parser_feed_sched;

  localparam int unsigned RW   = 32;
  localparam int unsigned NW   = 9;
  localparam int unsigned CW   = 4;   // narrow counters so saturation is reached
  localparam int unsigned FW   = NW * RW;
  localparam int          MAXC = (1 << CW) - 1;
`ifdef PARSER_TYPE_FILTER_EN
  localparam bit FILT_ON = 1'b1;
`else
  localparam bit FILT_ON = 1'b0;
`endif

  typedef struct packed {
    logic [RW-1:0] data;
    logic          last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [RW-1:0] s0_data, s1_data;
  logic          s0_valid, s0_last, s0_ready;
  logic          s1_valid, s1_last, s1_ready;
  logic          book_ready;
  logic [FW-1:0] frame;
  logic          dv, src;
  logic [CW-1:0] msg_cnt, err_cnt;
`ifdef PARSER_TYPE_FILTER_EN
  logic [CW-1:0] filt_cnt;
`endif

  always #5 clk = ~clk;

  parser_feed_sched #(.REG_WIDTH(RW), .NUM_WORDS(NW), .CNT_WIDTH(CW)) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_s0_data    (s0_data),
    .i_s0_valid   (s0_valid),
    .i_s0_last    (s0_last),
    .o_s0_ready   (s0_ready),
    .i_s1_data    (s1_data),
    .i_s1_valid   (s1_valid),
    .i_s1_last    (s1_last),
    .o_s1_ready   (s1_ready),
    .i_book_ready (book_ready),
    .o_frame      (frame),
    .o_data_valid (dv),
    .o_src        (src),
    .o_msg_count  (msg_cnt),
    .o_err_count  (err_cnt)
`ifdef PARSER_TYPE_FILTER_EN
    ,
    .o_filt_count (filt_cnt)
`endif
  );

  int    n_cmp = 0;
  int    n_bad = 0;
  int    n_pulse = 0;
  bit    pulse_src[$];
  beat_t q0[$], q1[$];
  int    gap_pct = 0;
  int    br_mode = 0;   // 0: book not ready, 1: ready, 2: random

  task automatic chk(input string nm, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chkv(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > MAXC) ? MAXC : v;
  endfunction

  function automatic bit type_ok(input logic [7:0] t);
    return !FILT_ON || (t == 8'h41) || (t == 8'h44) || (t == 8'h45);
  endfunction

  // ---------------- behavioural reference model ----------------
  bit            m_live = 1'b0;
  int            m_phase = 0;   // 0 waiting for a feed, 1 gathering, 2 discarding, 3 holding frame
  bit            m_owner = 1'b1;
  logic [RW-1:0] m_words[$];
  logic [FW-1:0] m_frame = '0;
  bit            m_src = 1'b0;
  bit            m_dv = 1'b0;
  int            m_msg = 0, m_err = 0, m_filt = 0;

  task automatic model_issue();
    if (!type_ok(m_words[0][7:0])) begin
      m_filt++;
      m_phase = 0;
    end else if (book_ready) begin
      for (int k = 0; k < NW; k++) m_frame[k*RW +: RW] = m_words[k];
      m_src = m_owner;
      m_dv  = 1'b1;
      m_msg++;
      m_phase = 0;
    end else begin
      m_phase = 3;
    end
  endtask

  // Predict outputs after the coming clock edge from the inputs presented now
  task automatic model_step();
    bit acc, l;
    logic [RW-1:0] d;
    if (rst) begin
      m_live = 1'b1; m_phase = 0; m_owner = 1'b1; m_words.delete();
      m_frame = '0; m_src = 1'b0; m_dv = 1'b0; m_msg = 0; m_err = 0; m_filt = 0;
      return;
    end
    if (!m_live) return;
    m_dv = 1'b0;
    acc  = (m_phase == 1 || m_phase == 2) && (m_owner ? s1_valid : s0_valid);
    d    = m_owner ? s1_data : s0_data;
    l    = m_owner ? s1_last : s0_last;
    case (m_phase)
      0: if (s0_valid || s1_valid) begin
        m_owner = (s0_valid && s1_valid) ? !m_owner : s1_valid;
        m_words.delete();
        m_phase = 1;
      end
      1: if (acc) begin
        m_words.push_back(d);
        if (l) begin
          if (m_words.size() == NW) model_issue();
          else begin m_err++; m_phase = 0; end
        end else if (m_words.size() == NW) m_phase = 2;
      end
      2: if (acc && l) begin m_err++; m_phase = 0; end
      3: model_issue();
      default: m_phase = 0;
    endcase
  endtask

  // Per-cycle compare against the model, then advance the model
  always @(negedge clk) begin : compare
    logic e_r0, e_r1;
    if (m_live) begin
      e_r0 = (m_phase == 1 || m_phase == 2) && !m_owner;
      e_r1 = (m_phase == 1 || m_phase == 2) && m_owner;
      chkv("s0_ready", 32'(s0_ready), 32'(e_r0));
      chkv("s1_ready", 32'(s1_ready), 32'(e_r1));
      chkv("data_valid", 32'(dv), 32'(m_dv));
      chkv("src", 32'(src), 32'(m_src));
      chk("frame", frame, m_frame);
      chkv("msg_count", 32'(msg_cnt), 32'(sat(m_msg)));
      chkv("err_count", 32'(err_cnt), 32'(sat(m_err)));
`ifdef PARSER_TYPE_FILTER_EN
      chkv("filt_count", 32'(filt_cnt), 32'(sat(m_filt)));
`endif
      if (dv === 1'b1) begin
        n_pulse++;
        pulse_src.push_back(src);
      end
    end
    model_step();
  end

  // ---------------- feed drivers ----------------
  initial begin : driver
    bit take0, take1;
    s0_valid = 1'b0; s0_last = 1'b0; s0_data = '0;
    s1_valid = 1'b0; s1_last = 1'b0; s1_data = '0;
    book_ready = 1'b0;
    forever begin
      @(negedge clk);
      take0 = s0_valid && s0_ready && !rst;
      take1 = s1_valid && s1_ready && !rst;
      @(posedge clk);
      #1;
      if (take0 && q0.size() > 0) void'(q0.pop_front());
      if (take1 && q1.size() > 0) void'(q1.pop_front());
      if (q0.size() > 0 && $urandom_range(0, 99) >= gap_pct) begin
        s0_valid = 1'b1; s0_data = q0[0].data; s0_last = q0[0].last;
      end else begin
        s0_valid = 1'b0; s0_data = $urandom; s0_last = 1'($urandom_range(0, 1));
      end
      if (q1.size() > 0 && $urandom_range(0, 99) >= gap_pct) begin
        s1_valid = 1'b1; s1_data = q1[0].data; s1_last = q1[0].last;
      end else begin
        s1_valid = 1'b0; s1_data = $urandom; s1_last = 1'($urandom_range(0, 1));
      end
      case (br_mode)
        0:       book_ready = 1'b0;
        1:       book_ready = 1'b1;
        default: book_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  task automatic push_msg(input int f, input int len, input logic [7:0] typ, input logic [RW-1:0] base);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = (i == 0) ? {base[RW-1:8], typ} : base + RW'(i);
      b.last = (i == len - 1);
      if (f == 0) q0.push_back(b);
      else        q1.push_back(b);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Leaves the caller just after a negedge; call cyc() before driving again
  task automatic wait_pulses(input int target, input int budget, input string nm);
    int t = 0;
    while (n_pulse < target && t < budget) begin
      @(negedge clk);
      #1;
      t++;
    end
    chkv({nm, "_pulses"}, 32'(n_pulse), 32'(target));
  endtask

  task automatic wait_drain(input int budget, input string nm);
    int t = 0;
    while ((q0.size() > 0 || q1.size() > 0) && t < budget) begin
      cyc();
      t++;
    end
    chkv({nm, "_drained"}, 32'(q0.size() + q1.size()), 32'd0);
    repeat (4) cyc();
  endtask

  initial begin : main
    logic [7:0] typs [5];
    int p_base, t, r, len;
    typs = '{8'h41, 8'h44, 8'h45, 8'h58, 8'h00};

    rst = 1'b1;
    repeat (3) cyc();
    rst = 1'b0;
    @(negedge clk); #1;
    chkv("reset_msg", 32'(msg_cnt), 32'd0);
    chkv("reset_err", 32'(err_cnt), 32'd0);
    chk("reset_frame", frame, '0);
    chkv("reset_src", 32'(src), 32'd0);
    chkv("reset_dv", 32'(dv), 32'd0);
    chkv("reset_ready", 32'({s0_ready, s1_ready}), 32'd0);

    // Single good frame from S0, words 0x41..0x49
    cyc();
    br_mode = 1;
    push_msg(0, 9, 8'h41, 32'h41);
    wait_pulses(1, 60, "t1");
    chkv("t1_word0", frame[0 +: RW], 32'h41);
    chkv("t1_word8", frame[8*RW +: RW], 32'h49);
    chkv("t1_src", 32'(src), 32'd0);
    chkv("t1_msg", 32'(msg_cnt), 32'd1);

    // Both feeds busy: S0 was granted last, so S1 wins the first tie
    cyc();
    push_msg(0, 9, 8'h44, 32'h1000);
    push_msg(1, 9, 8'h45, 32'h2000);
    push_msg(0, 9, 8'h44, 32'h3000);
    push_msg(1, 9, 8'h45, 32'h4000);
    wait_pulses(5, 200, "t2");
    if (pulse_src.size() >= 5) begin
      chkv("t2_src1", 32'(pulse_src[1]), 32'd1);
      chkv("t2_src2", 32'(pulse_src[2]), 32'd0);
      chkv("t2_src3", 32'(pulse_src[3]), 32'd1);
      chkv("t2_src4", 32'(pulse_src[4]), 32'd0);
    end

    // Short frame from S1 then a good one
    cyc();
    push_msg(1, 5, 8'h41, 32'h5000);
    wait_drain(100, "t3");
    chkv("t3_err", 32'(err_cnt), 32'd1);
    chkv("t3_no_pulse", 32'(n_pulse), 32'd5);
    push_msg(1, 9, 8'h41, 32'h6000);
    wait_pulses(6, 60, "t3b");
    chkv("t3b_src", 32'(src), 32'd1);
    chkv("t3b_word0", frame[0 +: RW], 32'h6041);

    // Long frame from S0: extra words dropped
    cyc();
    push_msg(0, 12, 8'h41, 32'h7000);
    wait_drain(100, "t4");
    chkv("t4_err", 32'(err_cnt), 32'd2);
    chkv("t4_no_pulse", 32'(n_pulse), 32'd6);

    // Book stalled, then released
    br_mode = 0;
    push_msg(0, 9, 8'h41, 32'h8000);
    wait_drain(100, "t5");
    repeat (20) cyc();
    chkv("t5_held_no_pulse", 32'(n_pulse), 32'd6);
    chkv("t5_held_ready", 32'({s0_ready, s1_ready}), 32'd0);
    br_mode = 1;
    wait_pulses(7, 4, "t5");
    chkv("t5_word8", frame[8*RW +: RW], 32'h8008);

    // Reset in the middle of a frame
    cyc();
    push_msg(1, 9, 8'h41, 32'h9000);
    t = 0;
    while (q1.size() > 6 && t < 50) begin cyc(); t++; end
    rst = 1'b1;
    q0.delete();
    q1.delete();
    cyc();
    cyc();
    rst = 1'b0;
    @(negedge clk); #1;
    chkv("t5r_msg", 32'(msg_cnt), 32'd0);
    chkv("t5r_err", 32'(err_cnt), 32'd0);
    chk("t5r_frame", frame, '0);
    chkv("t5r_dv", 32'(dv), 32'd0);
    chkv("t5r_ready", 32'({s0_ready, s1_ready}), 32'd0);
    p_base = n_pulse;
    cyc();

`ifdef PARSER_TYPE_FILTER_EN
    // Unsupported message type is filtered
    push_msg(0, 9, 8'h58, 32'h58);
    wait_drain(100, "t6");
    chkv("t6_filt", 32'(filt_cnt), 32'd1);
    chkv("t6_msg", 32'(msg_cnt), 32'd0);
    chkv("t6_no_pulse", 32'(n_pulse), 32'(p_base));
`endif

    // Randomized traffic with gaps, bad lengths and a flaky book
    gap_pct = 25;
    br_mode = 2;
    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 99);
      if (r < 70)      len = 9;
      else if (r < 85) len = $urandom_range(1, 8);
      else             len = $urandom_range(10, 12);
      push_msg($urandom_range(0, 1), len, typs[$urandom_range(0, 4)], $urandom);
    end
    wait_drain(20000, "rand");
    br_mode = 1;
    repeat (10) cyc();
    @(negedge clk); #1;
    if (n_pulse - p_base >= MAXC) chkv("rand_msg_saturated", 32'(msg_cnt), 32'(MAXC));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
